// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, constants and CRC helper for the ALU serial link
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND      = 3'b000,
        OP_OR       = 3'b001,
        OP_RST      = 3'b010,
        OP_ERR_CRC  = 3'b011,
        OP_ADD      = 3'b100,
        OP_SUB      = 3'b101,
        OP_ERR_OP   = 3'b110,
        OP_ERR_DATA = 3'b111
    } operation_t;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CMD  = 1'b1;

    typedef struct packed {
        logic err_data;
        logic err_crc;
        logic err_op;
    } rx_err_t;

    // x^4+x+1, init 0, message consumed MSB first
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = d[i] ^ c[3];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_rx_pkt.sv
// rtl/alu_rx_pkt.sv - start detection and bit shifting for one 11-bit packet
module alu_rx_pkt #(
    parameter int PKT_BITS = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic       pkt_busy,
    output logic       pkt_end,
    output logic       pkt_done,
    output logic       pkt_flag,
    output logic [7:0] pkt_byte,
    output logic       pkt_stop_ok
);
    localparam int CW = $clog2(PKT_BITS);
    localparam logic [CW-1:0] LAST = CW'(PKT_BITS - 1);

    logic [CW-1:0]       bit_cnt;
    logic [PKT_BITS-3:0] shreg;

    // Stop bit is on sin this cycle; the frame FSM uses this to enter CHECK on time
    assign pkt_end = pkt_busy && (bit_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_busy    <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            pkt_done    <= 1'b0;
            pkt_flag    <= 1'b0;
            pkt_byte    <= '0;
            pkt_stop_ok <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            shreg    <= {shreg[PKT_BITS-4:0], sin};
            if (!pkt_busy) begin
                if (!sin) begin
                    pkt_busy <= 1'b1;
                    bit_cnt  <= CW'(1);
                end
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
                if (pkt_end) begin
                    pkt_busy    <= 1'b0;
                    pkt_done    <= 1'b1;
                    pkt_flag    <= shreg[PKT_BITS-3];
                    pkt_byte    <= shreg[7:0];
                    pkt_stop_ok <= sin;
                end
            end
        end
    end

endmodule

// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - frame FSM, byte storage, CRC/opcode checks and timeout for the ALU input link
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int DATA_PKTS   = 8,
    parameter int PKT_BITS    = 11,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_b,
    output logic [31:0] out_a,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err
);
    localparam int PC_W = $clog2(DATA_PKTS + 1);
    localparam int IW   = $clog2(DATA_PKTS);
    localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [PC_W-1:0] PC_FULL = PC_W'(DATA_PKTS);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, EMIT} state_t;

    state_t                    state;
    logic [PC_W-1:0]           pkt_cnt;
    logic [TW-1:0]             to_cnt;
    logic [DATA_PKTS-1:0][7:0] data_q;
    logic [2:0]                op_q;
    logic [3:0]                crc_q;
    logic                      err_data_q;

    logic       pkt_busy, pkt_end, pkt_done, pkt_flag, pkt_stop_ok;
    logic [7:0] pkt_byte;

    alu_rx_pkt #(.PKT_BITS(PKT_BITS)) u_pkt (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .pkt_busy    (pkt_busy),
        .pkt_end     (pkt_end),
        .pkt_done    (pkt_done),
        .pkt_flag    (pkt_flag),
        .pkt_byte    (pkt_byte),
        .pkt_stop_ok (pkt_stop_ok)
    );

    logic [31:0] frame_b, frame_a;
    logic [3:0]  crc_calc;
    logic        op_ok, to_run;
    rx_err_t     emit_err;

    assign frame_b  = {data_q[0], data_q[1], data_q[2], data_q[3]};
    assign frame_a  = {data_q[4], data_q[5], data_q[6], data_q[7]};
    assign crc_calc = crc4({frame_b, frame_a, 1'b1, op_q});
    assign op_ok    = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) || (op_q == OP_SUB);
    assign to_run   = ((state == IDLE) && (pkt_cnt != '0)) || (state == SHIFT);

    // Error priority: framing beats CRC beats opcode, so at most one flag is raised
    always_comb begin
        emit_err = '0;
        if (err_data_q)
            emit_err.err_data = 1'b1;
        else if (crc_calc != crc_q)
            emit_err.err_crc = 1'b1;
        else if (!op_ok)
            emit_err.err_op = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pkt_cnt    <= '0;
            to_cnt     <= '0;
            data_q     <= '0;
            op_q       <= '0;
            crc_q      <= '0;
            err_data_q <= 1'b0;
            out_valid  <= 1'b0;
            out_b      <= '0;
            out_a      <= '0;
            out_op     <= '0;
            out_err    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE:  if (pkt_busy) state <= SHIFT;
                SHIFT: if (pkt_end) state <= CHECK;
                CHECK: begin
                    state <= IDLE;
                    if (!pkt_done || !pkt_stop_ok) begin
                        err_data_q <= 1'b1;
                    end else if (pkt_flag == PKT_CMD) begin
                        op_q  <= pkt_byte[6:4];
                        crc_q <= pkt_byte[3:0];
                        if (pkt_cnt != PC_FULL) err_data_q <= 1'b1;
                        state <= EMIT;
                    end else if (pkt_cnt < PC_FULL) begin
                        data_q[pkt_cnt[IW-1:0]] <= pkt_byte;
                        pkt_cnt                 <= pkt_cnt + PC_W'(1);
                    end else begin
                        err_data_q <= 1'b1;
                    end
                end
                EMIT: begin
                    out_valid  <= 1'b1;
                    out_b      <= frame_b;
                    out_a      <= frame_a;
                    out_op     <= op_q;
                    out_err    <= emit_err;
                    pkt_cnt    <= '0;
                    err_data_q <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // An abandoned partial frame is dropped without any output strobe
            if ((TIMEOUT_CYC != 0) && to_run) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt     <= '0;
                    pkt_cnt    <= '0;
                    err_data_q <= 1'b0;
                    state      <= IDLE;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule
